sha256_block_engine: RTL and testbench

//  Clocked, parametrised SHA-256 compression engine: accepts one 512-bit message block per handshake,

---
 rtl/sha256_block_engine_if.sv | 20 ++
 rtl/sha256_block_engine.sv | 145 ++++++++++++++
 tb/tb_sha256_block_engine.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_block_engine_if.sv
// Handshake bundle between a block producer and the SHA-256 compression engine.
interface sha256_block_engine_if;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_block;
    logic         in_init;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_digest;

    modport master (
        output in_valid, in_block, in_init, out_ready,
        input  in_ready, out_valid, out_digest
    );

    modport slave (
        input  in_valid, in_block, in_init, out_ready,
        output in_ready, out_valid, out_digest
    );
endinterface

// File: rtl/sha256_block_engine.sv
// SHA-256 compression engine: one 512-bit block per handshake, RPC rounds per clock,
// chaining register kept internally so multi-block messages need only in_init=0.
//
//  state   | meaning
//  --------+-------------------------------------------------------------
//  S_IDLE  | waiting for a block, in_ready high
//  S_ROUND | running RPC rounds per cycle until the round counter hits 64
//  S_FINAL | add working vars to the base hash, load chain and out_digest
//  S_DONE  | out_valid high until the consumer takes the digest
module sha256_block_engine #(
    parameter int RPC      = 1,
    parameter int OUT_HOLD = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sha256_block_engine_if.slave  bus,
    output logic                  busy
);

    typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} state_t;

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    state_t      state;
    logic [6:0]  ctr;
    logic [31:0] w      [16];
    logic [31:0] st     [8];
    logic [31:0] base   [8];
    logic [31:0] chain  [8];
    logic [31:0] w_nxt  [16];
    logic [31:0] st_nxt [8];

    // RPC unrolled rounds; the schedule window is extended by RPC words and slid forward.
    always_comb begin
        logic [31:0] ext [16+RPC];
        logic [31:0] v   [8];
        logic [31:0] t1, t2;
        logic [5:0]  kidx;
        for (int i = 0; i < 16; i++) ext[i] = w[i];
        for (int j = 0; j < RPC; j++)
            ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
        for (int i = 0; i < 8; i++) v[i] = st[i];
        for (int j = 0; j < RPC; j++) begin
            kidx = ctr[5:0] + 6'(j);
            t1 = v[7] + bsig1(v[4]) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[kidx] + ext[j];
            t2 = bsig0(v[0]) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int k = 7; k > 0; k--) v[k] = v[k-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++)  st_nxt[i] = v[i];
        for (int i = 0; i < 16; i++) w_nxt[i]  = ext[i+RPC];
    end

    // Control FSM with registered handshake/status outputs and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            ctr            <= '0;
            bus.in_ready   <= 1'b1;
            bus.out_valid  <= 1'b0;
            bus.out_digest <= '0;
            busy           <= 1'b0;
            for (int i = 0; i < 16; i++) w[i] <= '0;
            for (int i = 0; i < 8; i++) begin
                st[i]    <= '0;
                base[i]  <= '0;
                chain[i] <= IV[i];
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        for (int i = 0; i < 16; i++) w[i] <= bus.in_block[511-32*i -: 32];
                        for (int i = 0; i < 8; i++) begin
                            st[i]   <= bus.in_init ? IV[i] : chain[i];
                            base[i] <= bus.in_init ? IV[i] : chain[i];
                        end
                        ctr          <= '0;
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b1;
                        state        <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    for (int i = 0; i < 16; i++) w[i] <= w_nxt[i];
                    for (int i = 0; i < 8; i++)  st[i] <= st_nxt[i];
                    ctr <= ctr + 7'(RPC);
                    if (ctr == 7'(64 - RPC)) state <= S_FINAL;
                end
                S_FINAL: begin
                    for (int i = 0; i < 8; i++) begin
                        chain[i]                       <= base[i] + st[i];
                        bus.out_digest[255-32*i -: 32] <= base[i] + st[i];
                    end
                    bus.out_valid <= 1'b1;
                    busy          <= 1'b0;
                    state         <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        if (OUT_HOLD == 0) bus.out_digest <= '0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_engine.sv
// Self-checking bench for sha256_block_engine against a plain SHA-256 reference model.
module tb_sha256_block_engine;

    localparam int RPC      = 1;
    localparam int OUT_HOLD = 1;
    localparam int NCYC     = 64 / RPC;

    localparam logic [255:0] IV_ALL = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] BLK_TWO0  = {448'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071,
                                          32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_TWO1  = {480'h0, 32'h000001c0};
    localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   checks = 0;
    int   errors = 0;
    logic [255:0] model_chain = IV_ALL;

    sha256_block_engine_if bus();

    sha256_block_engine #(.RPC(RPC), .OUT_HOLD(OUT_HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook SHA-256 compression: full 64-word schedule, then 64 rounds, then feed-forward.
    function automatic logic [255:0] model_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] wv [64];
        logic [31:0] hv [8];
        logic [31:0] v  [8];
        logic [31:0] t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) wv[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            wv[i] = (rr(wv[i-2], 17) ^ rr(wv[i-2], 19) ^ (wv[i-2] >> 10)) + wv[i-7]
                  + (rr(wv[i-15], 7) ^ rr(wv[i-15], 18) ^ (wv[i-15] >> 3)) + wv[i-16];
        for (int i = 0; i < 8; i++) begin
            hv[i] = hin[255-32*i -: 32];
            v[i]  = hv[i];
        end
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + wv[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int k = 7; k > 0; k--) v[k] = v[k-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hv[i] + v[i];
        return r;
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    // Issue one block, update the model chain, and wait (bounded) for out_valid.
    // lat counts clock edges from the accepting edge (1) to the edge raising out_valid.
    task automatic send_block(input logic [511:0] blk, input logic init,
                              output logic [255:0] dig, output logic [255:0] exp_dig,
                              output int lat, output bit ok);
        ok  = 0;
        lat = 0;
        for (int i = 0; i < 200 && bus.in_ready !== 1'b1; i++) begin
            @(posedge clk); #1;
        end
        exp_dig     = model_compress(init ? IV_ALL : model_chain, blk);
        model_chain = exp_dig;
        bus.in_valid = 1'b1;
        bus.in_block = blk;
        bus.in_init  = init;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            lat++;
            bus.in_valid = 1'b0;
            if (bus.out_valid === 1'b1) begin
                ok = 1;
                break;
            end
        end
        dig = bus.out_digest;
    endtask

    task automatic accept_digest();
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.out_digest !== 256'h0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b digest=%h, want 1 0 0 0",
                     bus.in_ready, bus.out_valid, busy, bus.out_digest);
        end
        rst_n = 1'b1;
        model_chain = IV_ALL;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b busy=%b, want 1 0", bus.in_ready, busy);
        end
    endtask

    task automatic test_known_vectors();
        logic [255:0] dig, exp_dig;
        int lat;
        bit ok;
        send_block(BLK_ABC, 1'b1, dig, exp_dig, lat, ok);
        checks++;
        if (!ok || dig !== DIG_ABC) begin
            errors++;
            $display("FAIL abc_digest: got %h want %h (ok=%0d)", dig, DIG_ABC, ok);
        end
        checks++;
        if (lat !== NCYC + 2) begin
            errors++;
            $display("FAIL abc_latency: got %0d want %0d", lat, NCYC + 2);
        end
        accept_digest();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_digest !== (OUT_HOLD != 0 ? DIG_ABC : 256'h0)) begin
            errors++;
            $display("FAIL abc_after_accept: out_valid=%b in_ready=%b digest=%h", bus.out_valid, bus.in_ready, bus.out_digest);
        end

        send_block(BLK_EMPTY, 1'b1, dig, exp_dig, lat, ok);
        checks++;
        if (!ok || dig !== DIG_EMPTY) begin
            errors++;
            $display("FAIL empty_digest: got %h want %h", dig, DIG_EMPTY);
        end
        accept_digest();

        send_block(BLK_TWO0, 1'b1, dig, exp_dig, lat, ok);
        checks++;
        if (!ok || dig !== exp_dig) begin
            errors++;
            $display("FAIL two_block0: got %h want %h", dig, exp_dig);
        end
        accept_digest();
        send_block(BLK_TWO1, 1'b0, dig, exp_dig, lat, ok);
        checks++;
        if (!ok || dig !== DIG_TWO) begin
            errors++;
            $display("FAIL two_block1: got %h want %h", dig, DIG_TWO);
        end
        accept_digest();
    endtask

    task automatic test_random();
        logic [255:0] dig, exp_dig;
        logic [511:0] blk;
        logic init;
        int lat;
        bit ok;
        for (int n = 0; n < 8; n++) begin
            blk  = rand_block();
            init = 1'($urandom_range(0, 1));
            send_block(blk, init, dig, exp_dig, lat, ok);
            checks++;
            if (!ok || dig !== exp_dig || lat !== NCYC + 2) begin
                errors++;
                $display("FAIL random_%0d: init=%b got %h lat %0d want %h lat %0d", n, init, dig, lat, exp_dig, NCYC + 2);
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            accept_digest();
        end
    endtask

    task automatic test_hold();
        logic [255:0] dig, exp_dig, exp2;
        logic [511:0] blk2;
        int lat;
        bit ok, got;
        send_block(rand_block(), 1'b1, dig, exp_dig, lat, ok);
        checks++;
        if (!ok || dig !== exp_dig) begin
            errors++;
            $display("FAIL hold_first: got %h want %h", dig, exp_dig);
        end
        blk2 = rand_block();
        bus.in_valid = 1'b1;
        bus.in_block = blk2;
        bus.in_init  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_digest !== exp_dig || bus.in_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable_%0d: out_valid=%b in_ready=%b busy=%b digest=%h want 1 0 0 %h",
                         i, bus.out_valid, bus.in_ready, busy, bus.out_digest, exp_dig);
            end
        end
        accept_digest();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0
            || bus.out_digest !== (OUT_HOLD != 0 ? exp_dig : 256'h0)) begin
            errors++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b busy=%b digest=%h",
                     bus.out_valid, bus.in_ready, busy, bus.out_digest);
        end
        exp2 = model_compress(IV_ALL, blk2);
        model_chain = exp2;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL hold_next_taken: busy=%b in_ready=%b want 1 0", busy, bus.in_ready);
        end
        got = 0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) got = 1;
        end
        checks++;
        if (!got || bus.out_digest !== exp2) begin
            errors++;
            $display("FAIL hold_second_digest: got %h want %h (seen=%0d)", bus.out_digest, exp2, got);
        end
        accept_digest();
    endtask

    task automatic test_abort();
        logic [255:0] dig, exp_dig;
        int lat;
        bit ok;
        bus.in_valid = 1'b1;
        bus.in_block = BLK_ABC;
        bus.in_init  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (30 / RPC) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_midround: busy=%b out_valid=%b want 1 0", busy, bus.out_valid);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.out_digest !== 256'h0) begin
            errors++;
            $display("FAIL abort_reset: out_valid=%b in_ready=%b busy=%b digest=%h want 0 1 0 0",
                     bus.out_valid, bus.in_ready, busy, bus.out_digest);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_chain = IV_ALL;
        @(posedge clk); #1;
        send_block(BLK_ABC, 1'b0, dig, exp_dig, lat, ok);
        checks++;
        if (!ok || dig !== DIG_ABC) begin
            errors++;
            $display("FAIL abort_reissue: got %h want %h", dig, DIG_ABC);
        end
        accept_digest();
    endtask

    task automatic test_back_to_back();
        logic [255:0] expq [$];
        logic [255:0] e;
        logic init;
        int sent = 0, got = 0, cyc = 0, prev = -1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 600 && got < 4; i++) begin
            if (bus.in_ready === 1'b1 && sent < 4) begin
                init = 1'($urandom_range(0, 1));
                bus.in_block = rand_block();
                bus.in_init  = init;
                bus.in_valid = 1'b1;
                e = model_compress(init ? IV_ALL : model_chain, bus.in_block);
                model_chain = e;
                expq.push_back(e);
                sent++;
            end else if (sent >= 4) begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (bus.out_valid === 1'b1) begin
                e = (expq.size() > 0) ? expq.pop_front() : 256'h0;
                checks++;
                if (bus.out_digest !== e) begin
                    errors++;
                    $display("FAIL b2b_digest_%0d: got %h want %h", got, bus.out_digest, e);
                end
                if (prev >= 0) begin
                    checks++;
                    if (cyc - prev !== NCYC + 3) begin
                        errors++;
                        $display("FAIL b2b_period_%0d: got %0d want %0d", got, cyc - prev, NCYC + 3);
                    end
                end
                prev = cyc;
                got++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++;
        if (got !== 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d digests want 4", got);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_block  = '0;
        bus.in_init   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_known_vectors();
        test_random();
        test_hold();
        test_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
